result_ascii_encoder: RTL and testbench
=======================================

// Module: result_ascii_encoder
// PURPOSE
//   Output-side formatter of the co-processor. Takes a signed binary result from
//   the ALU and emits it as a stream of ASCII bytes toward the UART transmitter:
//   optional '-', decimal digits MSB-first without leading zeros, then a terminator.
//   It is the outbound counterpart of the ASCII command decoder on the input path.
// PARAMETERS
//   DATA_W     16     result width, two's complement
//   MAX_DIGITS 5      decimal digit capacity; must satisfy 10^MAX_DIGITS >= 2^(DATA_W-1)
//   TERM_CHAR  8'h0A  single terminator byte; ignored when CRLF_TERM_EN is defined
// PORTS
//   clk       in   1       clock, rising edge
//   reset     in   1       synchronous, active-high
//   res_data  in   DATA_W  signed result to format
//   res_valid in   1       res_data is valid
//   res_ready out  1       encoder can accept a result (high only in IDLE)
//   tx_data   out  8       ASCII byte toward the UART transmitter
//   tx_valid  out  1       tx_data is valid
//   tx_ready  in   1       transmitter accepts tx_data this cycle
//   busy      out  1       high from the accept edge until the terminator transfers
// BEHAVIOUR
//   Reset: res_ready=1, tx_valid=0, tx_data=8'h00, busy=0, FSM=IDLE, registers cleared.
//   Result accept: on the edge where res_valid&&res_ready. Latch neg=res_data[MSB]
//     and the unsigned DATA_W-bit magnitude. -2^(DATA_W-1) yields a correct magnitude.
//   FSM: IDLE -> CONVERT -> EMIT_SIGN (only if neg) -> EMIT_DIG -> EMIT_TERM -> IDLE.
//   CONVERT: sequential double-dabble, exactly DATA_W cycles. Then find the index of
//     the first nonzero BCD digit. Magnitude 0 emits a single '0' (0x30).
//   Latency: tx_valid rises on edge DATA_W+1 after the accept edge, with the first byte.
//   Byte handshake: a byte transfers on an edge where tx_valid&&tx_ready. While
//     tx_valid=1 and tx_ready=0, tx_data stays stable and is neither dropped nor
//     repeated. The next byte appears the cycle after a transfer. tx_ready is ignored
//     while tx_valid=0.
//   Throughput: one byte per cycle when tx_ready is held high. There are no gaps
//     between bytes of one result.
//   Digit byte = 8'h30 + BCD digit. Sign byte = 8'h2D.
//   After the terminator transfers: IDLE, res_ready=1 on the next cycle. There is no
//     result queueing. res_valid is ignored while busy.
//   reset during any state: on that edge, abandon the stream with no partial
//     terminator. All outputs return to their reset values.
// CONFIGURATION
//   CRLF_TERM_EN defined: the terminator is two bytes, 8'h0D then 8'h0A (EMIT_TERM
//     sends two bytes, each with its own handshake).
//   CRLF_TERM_EN undefined: the terminator is the single byte TERM_CHAR.
// STRUCTURE
//   Shared package/include cop_ascii_pkg:
//     - ASCII constants CHAR_PLUS 8'h2B, CHAR_MINUS 8'h2D, CHAR_ZERO 8'h30,
//       CHAR_CR 8'h0D, CHAR_LF 8'h0A (shared with the input decoder).
//     - FSM state encoding localparams.
//   Sub-module bin_to_bcd_seq:
//     - start/done interface, DATA_W-cycle sequential double-dabble.
//     - Output: MAX_DIGITS x 4-bit BCD.
//   The top level holds the FSM, sign/terminator sequencing, digit index counter and
//     the output register.
// TESTING (tx_ready=1 unless stated; CRLF_TERM_EN undefined unless stated)
//   1. res_data=16'd0 -> 0x30,0x0A; first tx_valid exactly 17 cycles after accept.
//   2. res_data=16'd1234 -> 0x31,0x32,0x33,0x34,0x0A back-to-back; busy falls after 0x0A.
//   3. res_data=16'h8000 -> 0x2D,0x33,0x32,0x37,0x36,0x38,0x0A.
//   4. res_data=-16'd7, tx_ready low 3 cycles while tx_data=0x37 -> 0x37 is held
//      stable and sent once, then 0x0A. No drop, no duplicate.
//   5. res_data=16'd905, reset asserted after 2 bytes transfer -> tx_valid=0 and
//      res_ready=1 next cycle. A following 16'd5 yields 0x35,0x0A only.
//   6. CRLF_TERM_EN defined, res_data=16'd42 -> 0x34,0x32,0x0D,0x0A.
//      res_valid held high while busy -> exactly one result is accepted per stream.

Source files
------------

// File: rtl/cop_ascii_pkg.sv
// cop_ascii_pkg
//   Definitions shared by the co-processor ASCII front ends: the character
//   constants used by both the command decoder and the result encoder, the
//   result encoder's FSM state encoding, and a digit-to-character helper.
package cop_ascii_pkg;

   localparam logic [7:0] CHAR_PLUS  = 8'h2B;
   localparam logic [7:0] CHAR_MINUS = 8'h2D;
   localparam logic [7:0] CHAR_ZERO  = 8'h30;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CONVERT   = 3'd1;
   localparam logic [2:0] S_EMIT_SIGN = 3'd2;
   localparam logic [2:0] S_EMIT_DIG  = 3'd3;
   localparam logic [2:0] S_EMIT_TERM = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_CONVERT   = S_CONVERT,
      ST_EMIT_SIGN = S_EMIT_SIGN,
      ST_EMIT_DIG  = S_EMIT_DIG,
      ST_EMIT_TERM = S_EMIT_TERM
   } enc_state_t;

   // ASCII character for one BCD digit
   function automatic logic [7:0] dig_char(input logic [3:0] d);
      return CHAR_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential double-dabble binary-to-BCD converter. A start pulse loads the
//   unsigned input; the conversion then takes exactly DATA_W cycles, after
//   which done stays high and bcd stays stable until the next start.
// Ports
//   clk    in   1                  clock, rising edge
//   reset  in   1                  synchronous, active-high
//   start  in   1                  load bin and begin a conversion
//   bin    in   DATA_W             unsigned value to convert
//   done   out  1                  bcd holds the finished result
//   bcd    out  MAX_DIGITS x 4     BCD digits, [0] = units
module bin_to_bcd_seq #(
   parameter int DATA_W     = 16,
   parameter int MAX_DIGITS = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [DATA_W-1:0]            bin,
   output logic                         done,
   output logic [MAX_DIGITS-1:0][3:0]   bcd
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 4 * MAX_DIGITS;

   logic [DATA_W-1:0] shreg;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt;
   logic              run;

   // add-3 correction on every digit that would reach 10 or more after the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
         bcd_q <= '0;
         cnt   <= '0;
         run   <= 1'b0;
      end else if (start) begin
         shreg <= bin;
         bcd_q <= '0;
         cnt   <= CNT_W'(DATA_W);
         run   <= 1'b1;
      end else if (run && cnt != '0) begin
         shreg <= {shreg[DATA_W-2:0], 1'b0};
         bcd_q <= {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
         cnt   <= cnt - 1'b1;
      end
   end

   assign done = run && (cnt == '0);
   assign bcd  = bcd_q;

endmodule

// File: rtl/result_ascii_encoder.sv
// result_ascii_encoder
//   Formats a signed ALU result as ASCII toward the UART transmitter:
//   optional '-', decimal digits MSB-first without leading zeros, terminator.
//   Configuration macro CRLF_TERM_EN: when defined the terminator is CR, LF;
//   otherwise it is the single byte TERM_CHAR.
// Ports
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high
//   res_data   in   DATA_W   signed result
//   res_valid  in   1        res_data valid
//   res_ready  out  1        ready for a result (IDLE only)
//   tx_data    out  8        ASCII byte
//   tx_valid   out  1        tx_data valid
//   tx_ready   in   1        transmitter takes tx_data this cycle
//   busy       out  1        stream in progress
module result_ascii_encoder
   import cop_ascii_pkg::*;
#(
   parameter int         DATA_W     = 16,
   parameter int         MAX_DIGITS = 5,
   parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   output logic              res_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy
);

   localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

`ifdef CRLF_TERM_EN
   localparam logic [7:0] TERM_FIRST = CHAR_CR;
`else
   localparam logic [7:0] TERM_FIRST = TERM_CHAR;
`endif

   enc_state_t                       state, state_nxt;
   logic [7:0]                       tx_data_nxt;
   logic                             tx_valid_nxt;
   logic [IDX_W-1:0]                 idx, idx_nxt, msd;
   logic                             neg, neg_nxt;
   logic                             term_lf, term_lf_nxt;
   logic [DATA_W-1:0]                mag;
   logic                             accept, xfer, conv_done;
   logic [MAX_DIGITS-1:0][3:0]       digits;

   assign accept = (state == ST_IDLE) && res_valid;
   assign xfer   = tx_valid && tx_ready;

   // two's complement magnitude; the most negative value wraps to 2^(DATA_W-1),
   // which is the correct unsigned magnitude
   assign mag = res_data[DATA_W-1] ? (~res_data + 1'b1) : res_data;

   bin_to_bcd_seq #(
      .DATA_W     (DATA_W),
      .MAX_DIGITS (MAX_DIGITS)
   ) u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (accept),
      .bin   (mag),
      .done  (conv_done),
      .bcd   (digits)
   );

   // index of the most significant nonzero digit; 0 for a zero magnitude so
   // that a single '0' is emitted
   always_comb begin
      msd = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (digits[i] != 4'd0) msd = IDX_W'(i);
      end
   end

   always_comb begin
      state_nxt    = state;
      tx_data_nxt  = tx_data;
      tx_valid_nxt = tx_valid;
      idx_nxt      = idx;
      neg_nxt      = neg;
      term_lf_nxt  = term_lf;
      case (state)
         ST_IDLE: begin
            if (res_valid) begin
               neg_nxt   = res_data[DATA_W-1];
               state_nxt = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (conv_done) begin
               idx_nxt      = msd;
               tx_valid_nxt = 1'b1;
               if (neg) begin
                  state_nxt   = ST_EMIT_SIGN;
                  tx_data_nxt = CHAR_MINUS;
               end else begin
                  state_nxt   = ST_EMIT_DIG;
                  tx_data_nxt = dig_char(digits[msd]);
               end
            end
         end
         ST_EMIT_SIGN: begin
            if (xfer) begin
               state_nxt   = ST_EMIT_DIG;
               tx_data_nxt = dig_char(digits[idx]);
            end
         end
         ST_EMIT_DIG: begin
            if (xfer) begin
               if (idx == '0) begin
                  state_nxt   = ST_EMIT_TERM;
                  term_lf_nxt = 1'b0;
                  tx_data_nxt = TERM_FIRST;
               end else begin
                  idx_nxt     = idx - 1'b1;
                  tx_data_nxt = dig_char(digits[idx - 1'b1]);
               end
            end
         end
         ST_EMIT_TERM: begin
            if (xfer) begin
`ifdef CRLF_TERM_EN
               if (!term_lf) begin
                  term_lf_nxt = 1'b1;
                  tx_data_nxt = CHAR_LF;
               end else begin
                  state_nxt    = ST_IDLE;
                  tx_valid_nxt = 1'b0;
                  tx_data_nxt  = 8'h00;
               end
`else
               state_nxt    = ST_IDLE;
               tx_valid_nxt = 1'b0;
               tx_data_nxt  = 8'h00;
`endif
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            tx_valid_nxt = 1'b0;
            tx_data_nxt  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         idx      <= '0;
         neg      <= 1'b0;
         term_lf  <= 1'b0;
      end else begin
         state    <= state_nxt;
         tx_data  <= tx_data_nxt;
         tx_valid <= tx_valid_nxt;
         idx      <= idx_nxt;
         neg      <= neg_nxt;
         term_lf  <= term_lf_nxt;
      end
   end

   assign res_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_result_ascii_encoder.sv
// tb_result_ascii_encoder
//   Directed vectors for result_ascii_encoder. Honours CRLF_TERM_EN for the
//   expected terminator bytes.
module tb_result_ascii_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   always #5 clk = ~clk;

   result_ascii_encoder #(
      .DATA_W     (16),
      .MAX_DIGITS (5),
      .TERM_CHAR  (8'h0A)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

`ifdef CRLF_TERM_EN
   localparam int         TERM_N = 2;
   localparam logic [15:0] TERM_B = 16'h0D0A;
`else
   localparam int         TERM_N = 1;
   localparam logic [15:0] TERM_B = 16'h0A00;
`endif

   // cycle counter and transfer monitor; sampled on the falling edge
   int         cyc = 0;
   logic [7:0] got[$];
   int         rise_cyc = -1;
   logic       prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
      prev_v <= tx_valid;
      if (tx_valid && !prev_v) rise_cyc <= cyc;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // digit/sign bytes listed first-byte-leftmost; terminator appended per build
   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  n;
      logic        hold;
      logic [55:0] b;
   } vec_t;

   vec_t vecs[10];

   task automatic start(input logic [15:0] d, output int acc);
      int t;
      t = 0;
      while (!res_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("res_ready_before_start", {31'd0, res_ready}, 32'd1);
      res_data  = d;
      res_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
   endtask

   task automatic finish();
      int t;
      t = 0;
      while (busy && t < 300) begin
         @(negedge clk); t++;
      end
      chk("busy_fall_timeout", {31'd0, busy}, 32'd0);
      res_valid = 1'b0;
   endtask

   task automatic check_stream(input string nm, input vec_t v, input int base);
      int n_exp;
      n_exp = int'(v.n) + TERM_N;
      chk({nm, "_count"}, got.size() - base, n_exp);
      for (int i = 0; i < n_exp; i++) begin
         logic [7:0] e;
         if (i < int'(v.n)) e = v.b[55-8*i -: 8];
         else               e = TERM_B[15-8*(i-int'(v.n)) -: 8];
         if (base + i < got.size()) chk($sformatf("%s_byte%0d", nm, i), {24'd0, got[base+i]}, {24'd0, e});
      end
   endtask

   initial begin
      int acc, base, t;
      vec_t v;

      vecs[0] = '{data: 16'd0,     n: 4'd1, hold: 1'b0, b: 56'h30_000000000000};
      vecs[1] = '{data: 16'd1234,  n: 4'd4, hold: 1'b0, b: 56'h31323334_000000};
      vecs[2] = '{data: 16'h8000,  n: 4'd6, hold: 1'b0, b: 56'h2D333237363800};
      vecs[3] = '{data: 16'h7FFF,  n: 4'd5, hold: 1'b0, b: 56'h3332373637_0000};
      vecs[4] = '{data: 16'hFFFF,  n: 4'd2, hold: 1'b0, b: 56'h2D31_0000000000};
      vecs[5] = '{data: 16'd10,    n: 4'd2, hold: 1'b0, b: 56'h3130_0000000000};
      vecs[6] = '{data: 16'd100,   n: 4'd3, hold: 1'b0, b: 56'h313030_00000000};
      vecs[7] = '{data: 16'hD8F0,  n: 4'd6, hold: 1'b0, b: 56'h2D313030303000};
      vecs[8] = '{data: 16'd42,    n: 4'd2, hold: 1'b1, b: 56'h3432_0000000000};
      vecs[9] = '{data: 16'd5,     n: 4'd1, hold: 1'b0, b: 56'h35_000000000000};

      reset     = 1'b1;
      res_valid = 1'b0;
      res_data  = '0;
      tx_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_res_ready", {31'd0, res_ready}, 32'd1);
      chk("reset_tx_valid",  {31'd0, tx_valid},  32'd0);
      chk("reset_tx_data",   {24'd0, tx_data},   32'd0);
      chk("reset_busy",      {31'd0, busy},      32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // table of complete streams, with first-byte latency on each
      for (int i = 0; i < 10; i++) begin
         v    = vecs[i];
         base = got.size();
         start(v.data, acc);
         if (!v.hold) res_valid = 1'b0;
         finish();
         chk($sformatf("latency_v%0d", i), rise_cyc - acc, 17);
         check_stream($sformatf("v%0d", i), v, base);
         if (v.hold) begin
            // res_valid was held through the stream: nothing more may start
            repeat (5) @(negedge clk);
            chk("hold_single_accept_busy",  {31'd0, busy}, 32'd0);
            chk("hold_single_accept_bytes", got.size() - base, int'(v.n) + TERM_N);
         end
      end

      // back-pressure while '7' of -7 is presented
      base = got.size();
      start(16'hFFF9, acc);
      res_valid = 1'b0;
      @(posedge clk); #1;
      t = 0;
      while (!(tx_valid && tx_data == 8'h37) && t < 50) begin
         @(posedge clk); #1; t++;
      end
      tx_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h37});
      end
      tx_ready = 1'b1;
      finish();
      v = '{data: 16'hFFF9, n: 4'd2, hold: 1'b0, b: 56'h2D37_0000000000};
      check_stream("stall", v, base);

      // reset mid-stream after two bytes of 905
      @(posedge clk); #1;
      base = got.size();
      start(16'd905, acc);
      res_valid = 1'b0;
      @(posedge clk); #1;
      t = 0;
      while (got.size() - base < 2 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_tx_valid",  {31'd0, tx_valid},  32'd0);
      chk("abort_res_ready", {31'd0, res_ready}, 32'd1);
      chk("abort_busy",      {31'd0, busy},      32'd0);
      chk("abort_tx_data",   {24'd0, tx_data},   32'd0);
      chk("abort_count",     got.size() - base,  2);
      if (got.size() - base >= 2) begin
         chk("abort_byte0", {24'd0, got[base]},   32'h39);
         chk("abort_byte1", {24'd0, got[base+1]}, 32'h30);
      end
      base = got.size();
      start(16'd5, acc);
      res_valid = 1'b0;
      finish();
      check_stream("after_abort", vecs[9], base);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
